// File: rtl/adc_stream_uart_mc.sv
// Paced dual-channel ADC capture, channel-tagged 16-bit word FIFO, and a
// two-byte-per-word UART TX sequencer driven by single-byte UART commands.
module adc_stream_uart_mc #(
   parameter  int CONV_INTERVAL = 12500,
   parameter  int MAX_SAMPLES   = 20000,
   parameter  int CNT_W         = 16,
   parameter  int ADC_W         = 12,
   parameter  int FIFO_DEPTH    = 16,
   localparam int AW            = $clog2(FIFO_DEPTH),
   localparam int LW            = AW + 1,
   localparam int TW            = $clog2(CONV_INTERVAL)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   output logic             o_start_conv,
   input  logic             i_adc_valid,
   input  logic [ADC_W-1:0] i_adc_d0,
   input  logic [ADC_W-1:0] i_adc_d1,
   output logic             o_tx_act,
   output logic [7:0]       o_tx_data,
   input  logic             i_tx_busy,
   output logic             o_sampling_active,
   output logic [CNT_W-1:0] o_sample_count,
   output logic [LW-1:0]    o_fifo_level,
   output logic             o_overrun,
   output logic             o_uart_led
);

   typedef enum logic [2:0] {
      S_IDLE, S_HI_GUARD, S_HI_WAIT, S_LO_GUARD, S_LO_WAIT
   } tx_state_t;

   function automatic logic [15:0] f_word(input logic ch, input logic [ADC_W-1:0] d);
      f_word             = '0;
      f_word[15]         = ch;
      f_word[ADC_W-1:0]  = d;
   endfunction

   logic             r_active, r_start_conv, r_mode_ch0, r_mode_ch1;
   logic [TW-1:0]    r_timer;
   logic [CNT_W-1:0] r_count;
   logic             r_pend;
   logic [15:0]      r_word1;
   logic [15:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [LW-1:0]    r_level;
   logic             r_overrun, r_led;
   tx_state_t        r_state, w_nxt;
   logic             r_tx_act;
   logic [7:0]       r_tx_data, r_lo;

   logic             w_cmd_start, w_cmd_stop, w_accept, w_push, w_wr, w_full, w_empty;
   logic             w_pop, w_send_lo;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [15:0]      w_wdata;

   assign w_cmd_start = i_rx_valid && (i_rx_data == 8'h41 || i_rx_data == 8'h30 ||
                                       i_rx_data == 8'h31);
   assign w_cmd_stop  = i_rx_valid && (i_rx_data == 8'h53);
   assign w_accept    = i_adc_valid && r_active && !w_cmd_start;
   assign w_cnt_nxt   = r_count + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active     <= 1'b0;
         r_start_conv <= 1'b0;
         r_mode_ch0   <= 1'b0;
         r_mode_ch1   <= 1'b0;
         r_timer      <= '0;
         r_count      <= '0;
      end else begin
         r_start_conv <= 1'b0;
         if (w_cmd_start) begin
            r_active   <= 1'b1;
            r_count    <= '0;
            r_timer    <= '0;
            r_mode_ch0 <= (i_rx_data != 8'h31);
            r_mode_ch1 <= (i_rx_data != 8'h30);
         end else begin
            if (w_accept)
               r_count <= w_cnt_nxt;
            if (w_cmd_stop || (w_accept && w_cnt_nxt == CNT_W'(MAX_SAMPLES))) begin
               r_active <= 1'b0;
               r_timer  <= '0;
            end else if (r_active) begin
               r_start_conv <= (r_timer == TW'(CONV_INTERVAL - 1));
               r_timer      <= (r_timer == TW'(CONV_INTERVAL - 1)) ? '0 : r_timer + 1'b1;
            end
         end
      end
   end

   // Dual mode defers the ch1 word by one cycle; conversions are at least two
   // cycles apart, so the deferred push never collides with the next capture.
   assign w_push  = r_pend || w_accept;
   assign w_wdata = r_pend     ? r_word1 :
                    r_mode_ch0 ? f_word(1'b0, i_adc_d0) : f_word(1'b1, i_adc_d1);
   assign w_full  = (r_level == LW'(FIFO_DEPTH));
   assign w_empty = (r_level == '0);
   assign w_wr    = w_push && (!w_full || w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend    <= 1'b0;
         r_word1   <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_level   <= '0;
         r_overrun <= 1'b0;
         r_led     <= 1'b0;
      end else begin
         r_pend <= w_accept && r_mode_ch0 && r_mode_ch1;
         if (w_accept)
            r_word1 <= f_word(1'b1, i_adc_d1);
         if (w_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         if (w_wr && !w_pop)
            r_level <= r_level + 1'b1;
         else if (!w_wr && w_pop)
            r_level <= r_level - 1'b1;
         if (w_cmd_start)
            r_overrun <= 1'b0;
         if (w_push && !w_wr)
            r_overrun <= 1'b1;
         if (i_rx_valid && i_rx_data == 8'h43)
            r_led <= 1'b1;
         else if (i_rx_valid && i_rx_data == 8'h63)
            r_led <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr)
         r_mem[r_wptr] <= w_wdata;
   end

   always_comb begin
      w_nxt     = r_state;
      w_pop     = 1'b0;
      w_send_lo = 1'b0;
      case (r_state)
         S_IDLE: if (!w_empty && !i_tx_busy) begin
            w_pop = 1'b1;
            w_nxt = S_HI_GUARD;
         end
         S_HI_GUARD: w_nxt = S_HI_WAIT;
         S_HI_WAIT: if (!i_tx_busy) begin
            w_send_lo = 1'b1;
            w_nxt     = S_LO_GUARD;
         end
         S_LO_GUARD: w_nxt = S_LO_WAIT;
         S_LO_WAIT: if (!i_tx_busy) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_tx_act  <= 1'b0;
         r_tx_data <= '0;
         r_lo      <= '0;
      end else begin
         r_state  <= w_nxt;
         r_tx_act <= w_pop || w_send_lo;
         if (w_pop) begin
            r_tx_data <= r_mem[r_rptr][15:8];
            r_lo      <= r_mem[r_rptr][7:0];
         end else if (w_send_lo) begin
            r_tx_data <= r_lo;
         end
      end
   end

   assign o_start_conv      = r_start_conv;
   assign o_tx_act          = r_tx_act;
   assign o_tx_data         = r_tx_data;
   assign o_sampling_active = r_active;
   assign o_sample_count    = r_count;
   assign o_fifo_level      = r_level;
   assign o_overrun         = r_overrun;
   assign o_uart_led        = r_led;

endmodule

// File: tb/tb_adc_stream_uart_mc.sv
// Scoreboard bench: ADC and UART behavioural models feed an expected-byte queue
// that a monitor drains on every tx_act.
module tb_adc_stream_uart_mc;
   localparam int CI = 20, MAXS = 3, CNT_W = 16, ADC_W = 12, DEPTH = 4;
   localparam int LW = $clog2(DEPTH) + 1;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic [7:0]       rx_data = '0;
   logic             rx_valid = 1'b0, adc_valid = 1'b0;
   logic [ADC_W-1:0] adc_d0 = '0, adc_d1 = '0;
   logic             u_busy = 1'b0, hold = 1'b0, tx_busy;
   logic             start_conv, tx_act, sampling_active, overrun, uart_led;
   logic [7:0]       tx_data;
   logic [CNT_W-1:0] sample_count;
   logic [LW-1:0]    fifo_level;

   assign tx_busy = u_busy | hold;

   adc_stream_uart_mc #(.CONV_INTERVAL(CI), .MAX_SAMPLES(MAXS), .CNT_W(CNT_W),
                        .ADC_W(ADC_W), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_start_conv(start_conv), .i_adc_valid(adc_valid), .i_adc_d0(adc_d0),
      .i_adc_d1(adc_d1), .o_tx_act(tx_act), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
      .o_sampling_active(sampling_active), .o_sample_count(sample_count),
      .o_fifo_level(fifo_level), .o_overrun(overrun), .o_uart_led(uart_led));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0, n_sc = 0, u_dur = 2, t_cmd = 0;
   bit m_active = 0, m_ch0 = 0, m_ch1 = 0, m_blk = 0, use_fix = 0, a_acc = 0;
   int m_count = 0, m_lvl = 0, a_lat = 0;
   logic [ADC_W-1:0] fix_d0 = '0, fix_d1 = '0;
   logic [7:0] q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected bytes for one word: channel in bit 15, data right-aligned.
   task automatic push_word(input int ch, input int d);
      int w;
      if (m_blk && m_lvl >= DEPTH) return;
      if (m_blk) m_lvl++;
      w = ch * 32768 + d;
      q.push_back(8'(w / 256));
      q.push_back(8'(w % 256));
   endtask

   task automatic send(input logic [7:0] c);
      @(negedge clk);
      rx_data = c; rx_valid = 1'b1; t_cmd = cyc;
      case (c)
         8'h41: begin m_active = 1; m_count = 0; m_ch0 = 1; m_ch1 = 1; end
         8'h30: begin m_active = 1; m_count = 0; m_ch0 = 1; m_ch1 = 0; end
         8'h31: begin m_active = 1; m_count = 0; m_ch0 = 0; m_ch1 = 1; end
         8'h53: m_active = 0;
         default: ;
      endcase
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 400 && m_count < target; i++) @(negedge clk);
      chk("run_samples", m_count, target);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);
      repeat (6) @(negedge clk);
   endtask

   // ADC front-end: answers each start_conv after a random latency.
   initial forever begin
      @(negedge clk);
      if (rst_n && start_conv) begin
         a_lat = $urandom_range(1, 4);
         repeat (a_lat) @(negedge clk);
         adc_d0 = use_fix ? fix_d0 : ADC_W'($urandom_range(0, 4095));
         adc_d1 = use_fix ? fix_d1 : ADC_W'($urandom_range(0, 4095));
         adc_valid = 1'b1;
         a_acc = m_active;
         if (a_acc) begin
            m_count++;
            if (m_ch0) push_word(0, int'(adc_d0));
            if (m_ch1) push_word(1, int'(adc_d1));
            if (m_count == MAXS) m_active = 0;
         end
         @(negedge clk);
         adc_valid = 1'b0;
         if (a_acc && m_count == MAXS) begin
            chk("max_active", sampling_active, 0);
            chk("max_count", sample_count, MAXS);
         end
      end
   end

   // UART TX: busy for u_dur cycles starting the cycle after tx_act.
   initial forever begin
      @(negedge clk);
      if (rst_n && tx_act) begin
         @(posedge clk); #1 u_busy = 1'b1;
         repeat (u_dur) @(posedge clk);
         #1 u_busy = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && tx_act) begin
         chk("act_while_busy", tx_busy, 0);
         if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_tx: got %0h expected none", tx_data);
         end else begin
            chk("tx_byte", tx_data, q.pop_front());
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (start_conv) n_sc++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t1, sc0;
      repeat (3) @(negedge clk);
      chk("rst_outs", {start_conv, tx_act, sampling_active, overrun, uart_led}, 0);
      chk("rst_count", sample_count, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_txdata", tx_data, 0);
      rst_n = 1'b1;

      send(8'h43); chk("led_on", uart_led, 1);
      send(8'h63); chk("led_off", uart_led, 0);
      repeat (5) @(negedge clk);
      chk("idle_active", sampling_active, 0);

      // Dual mode with fixed data.
      use_fix = 1; fix_d0 = 12'h123; fix_d1 = 12'hABC; u_dur = 2;
      send(8'h41); chk("act_rise", sampling_active, 1);
      wait_done(MAXS); wait_drain();
      chk("dual_count", sample_count, MAXS);
      chk("dual_ovr", overrun, 0);

      // Channel-1 only; check start_conv latency and period.
      fix_d1 = 12'h7FF;
      send(8'h31);
      for (int i = 0; i < 100 && !start_conv; i++) @(negedge clk);
      chk("first_sc", cyc - t_cmd, CI + 1);
      t1 = cyc;
      @(negedge clk);
      for (int i = 0; i < 100 && !start_conv; i++) @(negedge clk);
      chk("sc_period", cyc - t1, CI);
      wait_done(MAXS); wait_drain();
      use_fix = 0;

      // Overrun with TX blocked.
      hold = 1'b1; m_blk = 1; m_lvl = 0;
      send(8'h41);
      wait_done(MAXS);
      repeat (5) @(negedge clk);
      chk("ovr_level", fifo_level, DEPTH);
      chk("ovr_flag", overrun, 1);
      hold = 1'b0; m_blk = 0;
      wait_drain();
      chk("ovr_empty", fifo_level, 0);

      // Stop after the first conversion.
      send(8'h41);
      wait_done(1);
      repeat (3) @(negedge clk);
      send(8'h53);
      chk("stop_active", sampling_active, 0);
      sc0 = n_sc;
      repeat (60) @(negedge clk);
      chk("stop_no_sc", n_sc - sc0, 0);
      chk("stop_count", sample_count, 1);
      wait_drain();

      // Randomized runs.
      for (int r = 0; r < 6; r++) begin
         logic [7:0] cmds [3];
         cmds[0] = 8'h41; cmds[1] = 8'h30; cmds[2] = 8'h31;
         u_dur = $urandom_range(1, 2);
         send(cmds[$urandom_range(0, 2)]);
         wait_done(MAXS); wait_drain();
         chk("rnd_count", sample_count, MAXS);
         chk("rnd_ovr", overrun, 0);
      end

      // Reset while the high byte is in flight.
      u_dur = 30;
      send(8'h41);
      for (int i = 0; i < 100 && !tx_act; i++) @(negedge clk);
      chk("pre_rst_act", tx_act, 1);
      repeat (2) @(negedge clk);
      chk("pre_rst_level", fifo_level, 1);
      rst_n = 1'b0; m_active = 0;
      #1;
      chk("mid_rst_act", tx_act, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_active", sampling_active, 0);
      q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_level", fifo_level, 0);
      chk("post_rst_active", sampling_active, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
